// File: rtl/spart_pkg.sv
// Shared constants, types and parameter checks for the SPART baud generator.
package spart_pkg;

  typedef logic [1:0] ioaddr_t;

  localparam ioaddr_t DB_LOW_ADDR  = 2'b10;
  localparam ioaddr_t DB_HIGH_ADDR = 2'b11;

  // Divisor must span more than one bus byte but no more than two; oversample >= 2.
  function automatic bit params_legal(input int unsigned bus_w,
                                      input int unsigned div_w,
                                      input int unsigned os);
    return (div_w >= bus_w + 1) && (div_w <= 2 * bus_w) && (os >= 2);
  endfunction

endpackage

// File: rtl/spart_tick_div.sv
// Baud tick divider: counts down from the active divisor, emits a registered
// rxEnable pulse each time the count hits zero and a txEnable pulse on every
// OVERSAMPLE-th rxEnable.
module spart_tick_div #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_rx_en,
  output logic             o_tx_en
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);

  logic             r_running, w_running_d;
  logic [DIV_W-1:0] r_count, w_count_d;
  logic [DIV_W-1:0] r_div, w_div_d;
  logic [OS_W-1:0]  r_os, w_os_d;
  logic             r_rx, r_tx;
  logic             w_zero, w_wrap;

  // Next-state: start on enable, decrement, reload and oversample wrap.
  always_comb begin
    w_running_d = r_running;
    w_count_d   = r_count;
    w_div_d     = r_div;
    w_os_d      = r_os;
    w_zero      = r_running & (r_count == '0);
    w_wrap      = w_zero & (r_os == OS_W'(OVERSAMPLE - 1));
    if (!r_running) begin
      if (i_en) begin
        w_running_d = 1'b1;
        w_div_d     = i_div;
        w_count_d   = i_div;
      end
    end else if (w_zero) begin
      w_div_d   = i_div;
      w_count_d = w_div_d;
    end else begin
      w_count_d = r_count - DIV_W'(1);
    end
    if (w_zero) begin
      w_os_d = w_wrap ? '0 : r_os + OS_W'(1);
    end
  end

  // State and registered tick pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_running <= 1'b0;
      r_count   <= '0;
      r_div     <= '0;
      r_os      <= '0;
      r_rx      <= 1'b0;
      r_tx      <= 1'b0;
    end else begin
      r_running <= w_running_d;
      r_count   <= w_count_d;
      r_div     <= w_div_d;
      r_os      <= w_os_d;
      r_rx      <= w_zero;
      r_tx      <= w_wrap;
    end
  end

  assign o_rx_en = r_rx;
  assign o_tx_en = r_tx;

endmodule

// File: rtl/spart_baud_gen.sv
// SPART divisor-buffer registers plus baud tick generation.
// Optional readback of the divisor bytes: define SPART_DB_READBACK_EN.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter int unsigned BUS_W      = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iocs,
  input  logic                   iorw,
  input  ioaddr_t                ioaddr,
  input  logic [BUS_W-1:0]       dataIn,
  output logic [BUS_W-1:0]       dataOut,
  output logic [BUS_W-1:0]       dbLow,
  output logic [DIV_W-BUS_W-1:0] dbHigh,
  output logic                   isReady,
  output logic                   rxEnable,
  output logic                   txEnable
);

  localparam int unsigned HI_W = DIV_W - BUS_W;

  if (!params_legal(BUS_W, DIV_W, OVERSAMPLE)) begin : g_bad_params
    $error("spart_baud_gen: illegal BUS_W/DIV_W/OVERSAMPLE combination");
  end

  logic [BUS_W-1:0] r_db_low, w_db_low_d;
  logic [HI_W-1:0]  r_db_high, w_db_high_d;
  logic             r_lo_loaded, w_lo_loaded_d;
  logic             r_hi_loaded, w_hi_loaded_d;
  logic             r_ready, w_ready_d;
  logic             w_wr_lo, w_wr_hi;

  // Write decode and next-state of the divisor registers and loaded flags.
  always_comb begin
    w_wr_lo       = iocs & ~iorw & (ioaddr == DB_LOW_ADDR);
    w_wr_hi       = iocs & ~iorw & (ioaddr == DB_HIGH_ADDR);
    w_db_low_d    = r_db_low;
    w_db_high_d   = r_db_high;
    if (w_wr_lo) w_db_low_d = dataIn;
    if (w_wr_hi) w_db_high_d = dataIn[HI_W-1:0];
    w_lo_loaded_d = r_lo_loaded | w_wr_lo;
    w_hi_loaded_d = r_hi_loaded | w_wr_hi;
    w_ready_d     = w_lo_loaded_d & w_hi_loaded_d;
  end

  // Divisor registers and loaded flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_low    <= '0;
      r_db_high   <= '0;
      r_lo_loaded <= 1'b0;
      r_hi_loaded <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_db_low    <= w_db_low_d;
      r_db_high   <= w_db_high_d;
      r_lo_loaded <= w_lo_loaded_d;
      r_hi_loaded <= w_hi_loaded_d;
      r_ready     <= w_ready_d;
    end
  end

  assign dbLow   = r_db_low;
  assign dbHigh  = r_db_high;
  assign isReady = r_ready;

  // Starts on the edge isReady asserts with the divisor as written on that edge,
  // so the first rxEnable lands divisor+1 cycles later.
  spart_tick_div #(
    .DIV_W      (DIV_W),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick_div (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_ready_d),
    .i_div   ({w_db_high_d, w_db_low_d}),
    .o_rx_en (rxEnable),
    .o_tx_en (txEnable)
  );

`ifdef SPART_DB_READBACK_EN
  logic [BUS_W-1:0] r_data_out, w_data_out_d, w_hi_ext;

  // Read decode; dataOut holds its value when not addressed.
  always_comb begin
    w_hi_ext            = '0;
    w_hi_ext[HI_W-1:0]  = r_db_high;
    w_data_out_d        = r_data_out;
    if (iocs & iorw & (ioaddr == DB_LOW_ADDR)) begin
      w_data_out_d = r_db_low;
    end else if (iocs & iorw & (ioaddr == DB_HIGH_ADDR)) begin
      w_data_out_d = w_hi_ext;
    end
  end

  // Registered readback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_data_out <= '0;
    else     r_data_out <= w_data_out_d;
  end

  assign dataOut = r_data_out;
`else
  assign dataOut = '0;
`endif

endmodule

// File: tb/tb_spart_baud_gen.sv
// Directed self-checking bench for spart_baud_gen (BUS_W=8, DIV_W=16, OVERSAMPLE=4).
module tb_spart_baud_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iocs = 1'b0;
  logic       iorw = 1'b0;
  logic [1:0] ioaddr = 2'b00;
  logic [7:0] dataIn = 8'h00;
  logic [7:0] dataOut, dbLow, dbHigh;
  logic       isReady, rxEnable, txEnable;

  int n_tests = 0;
  int n_fail  = 0;

  spart_baud_gen #(
    .BUS_W      (8),
    .DIV_W      (16),
    .OVERSAMPLE (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .dataIn   (dataIn),
    .dataOut  (dataOut),
    .dbLow    (dbLow),
    .dbHigh   (dbHigh),
    .isReady  (isReady),
    .rxEnable (rxEnable),
    .txEnable (txEnable)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic bus_wr(input logic [1:0] addr, input logic [7:0] data);
    iocs = 1'b1; iorw = 1'b0; ioaddr = addr; dataIn = data;
    tick();
    iocs = 1'b0; dataIn = 8'h00;
  endtask

  task automatic bus_rd(input logic [1:0] addr);
    iocs = 1'b1; iorw = 1'b1; ioaddr = addr;
    tick();
    iocs = 1'b0; iorw = 1'b0;
  endtask

  // Records rx/tx over n cycles; bit k-1 is the sample after the k-th edge.
  task automatic capture(input int n, output logic [31:0] rx_m, output logic [31:0] tx_m);
    rx_m = '0;
    tx_m = '0;
    for (int k = 0; k < n; k++) begin
      tick();
      rx_m[k] = rxEnable;
      tx_m[k] = txEnable;
    end
  endtask

  logic [31:0] rx_m, tx_m;
  int          rx_cnt;

  initial begin
    // 1: reset, mid-stream asynchronous reset, idle silence
    do_reset();
    bus_wr(2'b10, 8'h55);
    check_eq("pre_rst_lo", {24'h0, dbLow}, 32'h55);
    rst = 1'b1;
    #2;
    check_eq("async_rst_lo", {24'h0, dbLow}, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check_eq("rst_outs", {dataOut, dbLow, dbHigh, 5'b0, isReady, rxEnable, txEnable}, 32'h0);
    bus_wr(2'b10, 8'h01);
    bus_wr(2'b10, 8'h02);
    rx_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      rx_cnt += int'(rxEnable) + int'(txEnable);
    end
    check_eq("idle_pulses", rx_cnt, 0);
    check_eq("lo_only_not_ready", {31'h0, isReady}, 32'h0);

    // 2: register writes and ignored accesses
    do_reset();
    bus_wr(2'b10, 8'hAB);
    check_eq("db_low_ab", {24'h0, dbLow}, 32'hAB);
    check_eq("ready_after_lo", {31'h0, isReady}, 32'h0);
    bus_wr(2'b11, 8'hCD);
    check_eq("db_high_cd", {24'h0, dbHigh}, 32'hCD);
    check_eq("ready_after_hi", {31'h0, isReady}, 32'h1);
    iocs = 1'b0; iorw = 1'b0; ioaddr = 2'b10; dataIn = 8'h11;
    tick();
    iocs = 1'b1; iorw = 1'b1; ioaddr = 2'b11; dataIn = 8'h22;
    tick();
    iocs = 1'b1; iorw = 1'b0; ioaddr = 2'b01; dataIn = 8'h33;
    tick();
    iocs = 1'b0; iorw = 1'b0; dataIn = 8'h00;
    check_eq("ignored_wr", {16'h0, dbHigh, dbLow}, 32'hCDAB);

    // 3: divisor 3, OVERSAMPLE 4
    do_reset();
    bus_wr(2'b10, 8'h03);
    bus_wr(2'b11, 8'h00);
    capture(16, rx_m, tx_m);
    check_eq("div3_rx_p1", rx_m, 32'h8888);
    check_eq("div3_tx_p1", tx_m, 32'h8000);
    capture(16, rx_m, tx_m);
    check_eq("div3_rx_p2", rx_m, 32'h8888);
    check_eq("div3_tx_p2", tx_m, 32'h8000);

    // 4: change low byte mid-period; current period completes at 4
    tick();
    tick();
    bus_wr(2'b10, 8'h07);
    capture(17, rx_m, tx_m);
    check_eq("div7_rx", rx_m, 32'h0001_0101);
    check_eq("div7_tx", tx_m, 32'h0);

    // 5: divisor 0, then reset mid-run
    do_reset();
    bus_wr(2'b11, 8'h00);
    bus_wr(2'b10, 8'h00);
    capture(8, rx_m, tx_m);
    check_eq("div0_rx", rx_m, 32'hFF);
    check_eq("div0_tx", tx_m, 32'h88);
    rst = 1'b1;
    #1;
    check_eq("div0_rst_now", {29'h0, isReady, rxEnable, txEnable}, 32'h0);
    rx_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      rx_cnt += int'(rxEnable) + int'(txEnable) + int'(isReady);
    end
    check_eq("div0_rst_quiet", rx_cnt, 0);
    rst = 1'b0;
    tick();

    // 6: readback
    bus_wr(2'b10, 8'h2F);
    bus_wr(2'b11, 8'hA2);
    bus_rd(2'b10);
`ifdef SPART_DB_READBACK_EN
    check_eq("rd_low", {24'h0, dataOut}, 32'h2F);
`else
    check_eq("rd_low", {24'h0, dataOut}, 32'h0);
`endif
    bus_rd(2'b11);
`ifdef SPART_DB_READBACK_EN
    check_eq("rd_high", {24'h0, dataOut}, 32'hA2);
`else
    check_eq("rd_high", {24'h0, dataOut}, 32'h0);
`endif
    tick();
`ifdef SPART_DB_READBACK_EN
    check_eq("rd_hold", {24'h0, dataOut}, 32'hA2);
`else
    check_eq("rd_hold", {24'h0, dataOut}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spart_baud_gen.md
Name: spart_baud_gen

Overview:
Parametrised successor to the SPART divisor-buffer registers. It holds a bus-written baud divisor, split into low and high bytes, and runs the baud counter from it. The counter produces an oversampled receive-enable tick and a derived transmit-enable tick. It sits between the SPART bus interface and the rx/tx shift engines.

Parameters:
BUS_W, 8, width of dataIn/dataOut; one divisor byte per write
DIV_W, 16, divisor width; legal range BUS_W+1 .. 2*BUS_W
OVERSAMPLE, 16, rxEnable ticks per txEnable tick; legal range >=2

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
iocs  in  1  chip select
iorw  in  1  1 = read, 0 = write
ioaddr  in  2  2'b10 = DB low, 2'b11 = DB high; other codes are not this block's
dataIn  in  BUS_W  write data
dataOut  out  BUS_W  readback data; see Optional Feature
dbLow  out  BUS_W  divisor low byte register
dbHigh  out  DIV_W-BUS_W  divisor high part register
isReady  out  1  both divisor halves written since reset
rxEnable  out  1  one-cycle pulse, oversampled baud tick
txEnable  out  1  one-cycle pulse, baud tick

Behaviour:
- Reset (asynchronous, any time, including mid-count): dbLow=0, dbHigh=0, isReady=0, count=0, active divisor=0, oversample counter=0, rxEnable=0, txEnable=0, dataOut=0.
- Write strobe = iocs & ~iorw & ioaddr[1].
  - ioaddr[0]=0: dbLow <= dataIn on the rising edge.
  - ioaddr[0]=1: dbHigh <= dataIn[DIV_W-BUS_W-1:0]; the upper dataIn bits are ignored.
- iocs=0, iorw=1, or ioaddr[1]=0: no register changes.
- Loaded flags: loLoaded and hiLoaded are set by their respective writes and cleared only by rst.
  - isReady = loLoaded & hiLoaded, registered; it asserts on the edge that completes the second write.
  - Order of the two writes is irrelevant. Repeated writes to one half do not assert isReady.
- Counter idle while isReady=0: count holds 0, and rxEnable and txEnable stay 0.
- First edge with isReady=1: the active divisor latches {dbHigh,dbLow} and count loads it.
- Running: each cycle where count!=0, count decrements.
- When count==0:
  - rxEnable=1 for that cycle.
  - The active divisor re-latches {dbHigh,dbLow}.
  - count reloads the new value.
  - rxEnable period = divisor+1 cycles.
- Divisor 0 means rxEnable is asserted every cycle.
- Divisor writes while running never disturb the current count. They take effect at the next reload; a low/high pair split across a reload may briefly produce a mixed divisor, and this is documented as software's responsibility.
- Oversample counter: increments on each rxEnable and wraps at OVERSAMPLE-1 -> 0.
  - txEnable=1 in the same cycle as the rxEnable that causes the wrap.
  - First txEnable therefore comes on the OVERSAMPLE-th rxEnable.
- rxEnable and txEnable are registered outputs: count==0 is detected combinationally, and the pulse is registered.
  - Fixed latency: first rxEnable appears divisor+1 cycles after the isReady edge.

Optional Feature:
Macro SPART_DB_READBACK_EN.
- Defined: when iocs & iorw & ioaddr[1], dataOut is registered (1-cycle latency).
  - ioaddr[0]=0 returns dbLow; ioaddr[0]=1 returns dbHigh zero-extended.
  - Otherwise dataOut holds its last value.
- Undefined: dataOut is tied to 0 and no read decode logic is built.

Decomposition:
- Package spart_pkg:
  - constants DB_LOW_ADDR=2'b10, DB_HIGH_ADDR=2'b11
  - typedef for the ioaddr field
  - elaboration-time legality checks for DIV_W/BUS_W/OVERSAMPLE
- Sub-module spart_tick_div (count, reload, rxEnable/txEnable generation) is natural. The register file, flags and readback stay in the top.

Test Plan:
1. Reset with rst=1 mid-stream, then release -> all outputs 0; rxEnable silent for 100 cycles while isReady=0.
2. Write 8'hAB to 2'b10, then 8'hCD to 2'b11 (iocs=1, iorw=0) -> dbLow=AB, dbHigh=CD; isReady rises on the second edge. Writes with iocs=0 or iorw=1 leave both registers unchanged.
3. Divisor 16'h0003 with OVERSAMPLE=4 -> rxEnable every 4 cycles and txEnable every 16 cycles, coincident with the 4th rxEnable. First rxEnable comes 4 cycles after isReady.
4. While running with divisor 3, write dbLow=8'h07 -> current period finishes at 4 cycles; subsequent periods are 8 cycles.
5. Divisor 0 -> rxEnable high every cycle; txEnable every OVERSAMPLE cycles. Assert rst mid-run -> pulses stop immediately and isReady=0.
6. With SPART_DB_READBACK_EN defined, read 2'b10 then 2'b11 after writing 2F/A2 -> dataOut=2F, then A2, each one cycle later. Without the macro, dataOut stays 0.
